// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the next-PC source encoding.
// pc_src_e is also meant for debug tracing of the fetch redirect path.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_END_DEF   = 32'h0000_6FFC;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_J,
        SRC_ERET,
        SRC_EXC,
        SRC_HOLD
    } pc_src_e;

    // True for every source that breaks sequential fetch.
    function automatic logic is_redirect(input pc_src_e src);
        return (src == SRC_BR) || (src == SRC_J) ||
               (src == SRC_ERET) || (src == SRC_EXC);
    endfunction

endpackage

// File: rtl/pc_src_arb.sv
// Fixed-priority next-PC source arbiter: exc_req > eret > stall > jump > branch > sequential.
// Pure combinational; a hold selects the current PC as the target.
module pc_src_arb
    import cpu_pkg::*;
#(
    parameter int unsigned     AW      = 32,
    parameter logic [AW-1:0]   EXC_VEC = AW'(EXC_VEC_DEF)
) (
    input  logic          i_exc_req,
    input  logic          i_eret,
    input  logic          i_stall,
    input  logic          i_jump,
    input  logic          i_branch,
    input  logic [AW-1:0] i_jump_addr,
    input  logic [AW-1:0] i_branch_addr,
    input  logic [AW-1:0] i_epc,
    input  logic [AW-1:0] i_pc,
    input  logic [AW-1:0] i_pc_plus4,
    output pc_src_e       o_src,
    output logic [AW-1:0] o_target
);

    always_comb begin
        o_src    = SRC_SEQ;
        o_target = i_pc_plus4;
        if (i_exc_req) begin
            o_src    = SRC_EXC;
            o_target = EXC_VEC;
        end else if (i_eret) begin
            // eret forces word alignment; jump/branch targets pass through untouched.
            o_src    = SRC_ERET;
            o_target = {i_epc[AW-1:2], 2'b00};
        end else if (i_stall) begin
            o_src    = SRC_HOLD;
            o_target = i_pc;
        end else if (i_jump) begin
            o_src    = SRC_J;
            o_target = i_jump_addr;
        end else if (i_branch) begin
            o_src    = SRC_BR;
            o_target = i_branch_addr;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// IF-stage fetch PC register with next-PC selection, post-reset warm-up bubble
// and fetch-address fault detection on the registered PC.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = AW'(RESET_PC_DEF),
    parameter logic [AW-1:0]   EXC_VEC  = AW'(EXC_VEC_DEF),
    parameter logic [AW-1:0]   IM_BASE  = AW'(IM_BASE_DEF),
    parameter logic [AW-1:0]   IM_END   = AW'(IM_END_DEF)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          branch,
    input  logic [AW-1:0] branch_addr,
    input  logic          exc_req,
    input  logic          eret,
    input  logic [AW-1:0] epc,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    output logic          fetch_valid,
    output logic          fetch_fault,
    output logic          redirect
);

    logic [AW-1:0] r_pc;
    logic          r_valid;
    logic          r_redirect;

    logic [AW-1:0] w_pc_plus4;
    logic [AW-1:0] w_target;
    pc_src_e       w_src;
    logic          w_misalign;
    logic          w_out_of_range;

    assign w_pc_plus4 = r_pc + AW'(4);

    pc_src_arb #(
        .AW      (AW),
        .EXC_VEC (EXC_VEC)
    ) u_arb (
        .i_exc_req     (exc_req),
        .i_eret        (eret),
        .i_stall       (stall),
        .i_jump        (jump),
        .i_branch      (branch),
        .i_jump_addr   (jump_addr),
        .i_branch_addr (branch_addr),
        .i_epc         (epc),
        .i_pc          (r_pc),
        .i_pc_plus4    (w_pc_plus4),
        .o_src         (w_src),
        .o_target      (w_target)
    );

    // The first edge after reset only opens the fetch window; inputs are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_redirect <= 1'b0;
        end else if (!r_valid) begin
            r_valid    <= 1'b1;
            r_redirect <= 1'b0;
        end else begin
            r_pc <= w_target;
            if (w_src != SRC_HOLD) begin
                r_redirect <= is_redirect(w_src);
            end
        end
    end

    assign w_misalign     = |r_pc[1:0];
    assign w_out_of_range = (r_pc < IM_BASE) || (r_pc > IM_END);

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = r_valid;
    assign fetch_fault = r_valid & (w_misalign | w_out_of_range);
    assign redirect    = r_redirect;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a behavioural next-PC model.
module tb_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        stall, jump, branch, exc_req, eret;
    logic [31:0] jump_addr, branch_addr, epc;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, fetch_fault, redirect;

    logic        w_reset_n;
    logic [31:0] w_zero;
    logic [31:0] w_pc, w_pc_plus4;
    logic        w_valid, w_fault, w_redirect;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_redir;

    pc_unit dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .jump(jump), .jump_addr(jump_addr),
        .branch(branch), .branch_addr(branch_addr),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .fetch_fault(fetch_fault), .redirect(redirect)
    );

    pc_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .IM_END   (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk(clk), .reset_n(w_reset_n), .stall(1'b0),
        .jump(1'b0), .jump_addr(w_zero),
        .branch(1'b0), .branch_addr(w_zero),
        .exc_req(1'b0), .eret(1'b0), .epc(w_zero),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .fetch_valid(w_valid),
        .fetch_fault(w_fault), .redirect(w_redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_fault(input logic v, input logic [31:0] a);
        return v && ((a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC));
    endfunction

    task automatic clear_inputs();
        stall = 0; jump = 0; branch = 0; exc_req = 0; eret = 0;
        jump_addr = '0; branch_addr = '0; epc = '0;
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, settle.
    task automatic tick();
        @(posedge clk);
        if (!m_valid) begin
            m_valid = 1;
            m_redir = 0;
        end else if (exc_req) begin
            m_pc = 32'h4180; m_redir = 1;
        end else if (eret) begin
            m_pc = epc - (epc % 4); m_redir = 1;
        end else if (stall) begin
            // nothing moves
        end else if (jump) begin
            m_pc = jump_addr; m_redir = 1;
        end else if (branch) begin
            m_pc = branch_addr; m_redir = 1;
        end else begin
            m_pc = m_pc + 4; m_redir = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        m_pc = 32'h3000; m_valid = 0; m_redir = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pc !== 32'h3000 || fetch_valid !== 1'b0 || redirect !== 1'b0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h valid=%b redir=%b fault=%b want pc=3000 valid=0 redir=0 fault=0",
                     pc, fetch_valid, redirect, fetch_fault);
        end
        reset_n = 1;
        tick();
        checks++;
        if (pc !== 32'h3000 || fetch_valid !== 1'b1 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL warmup pc=%h valid=%b redir=%b want pc=3000 valid=1 redir=0", pc, fetch_valid, redirect);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (pc !== 32'h3000 + 32'(4 * i) || redirect !== 1'b0 || pc_plus4 !== pc + 32'd4) begin
                errors++;
                $display("FAIL seq_after_warmup pc=%h redir=%b p4=%h want pc=%h redir=0",
                         pc, redirect, pc_plus4, 32'h3000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_priority();
        tick(); tick();
        checks++;
        if (pc !== 32'h3010) begin
            errors++;
            $display("FAIL prio_setup pc=%h want 3010", pc);
        end
        stall = 1; jump = 1; jump_addr = 32'h3400; branch = 1; branch_addr = 32'h3200;
        tick();
        checks++;
        if (pc !== 32'h3010 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL stall_over_jump pc=%h redir=%b want pc=3010 redir=0", pc, redirect);
        end
        stall = 0;
        tick();
        checks++;
        if (pc !== 32'h3400 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL jump_over_branch pc=%h redir=%b want pc=3400 redir=1", pc, redirect);
        end
        jump = 0; stall = 1;
        tick();
        checks++;
        if (pc !== 32'h3400 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL stall_holds_redirect pc=%h redir=%b want pc=3400 redir=1", pc, redirect);
        end
        stall = 0;
        tick();
        checks++;
        if (pc !== 32'h3200 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL branch_taken pc=%h redir=%b want pc=3200 redir=1", pc, redirect);
        end
        clear_inputs();
        tick();
        checks++;
        if (pc !== 32'h3204 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL seq_clears_redirect pc=%h redir=%b want pc=3204 redir=0", pc, redirect);
        end
    endtask

    task automatic test_exception();
        stall = 1; exc_req = 1; eret = 1; epc = 32'h3050;
        tick();
        checks++;
        if (pc !== 32'h4180 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL exc_over_all pc=%h redir=%b want pc=4180 redir=1", pc, redirect);
        end
        clear_inputs();
        eret = 1; epc = 32'h3053; stall = 1;
        tick();
        checks++;
        if (pc !== 32'h3050 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL eret_aligned pc=%h redir=%b want pc=3050 redir=1", pc, redirect);
        end
        clear_inputs();
    endtask

    task automatic test_fault();
        logic [31:0] tgt [3];
        logic        exp_f [3];
        tgt[0] = 32'h3002; exp_f[0] = 1;
        tgt[1] = 32'h7000; exp_f[1] = 1;
        tgt[2] = 32'h6FF8; exp_f[2] = 0;
        for (int i = 0; i < 3; i++) begin
            jump = 1; jump_addr = tgt[i];
            tick();
            checks++;
            if (pc !== tgt[i] || fetch_fault !== exp_f[i]) begin
                errors++;
                $display("FAIL fault_jump pc=%h fault=%b want pc=%h fault=%b", pc, fetch_fault, tgt[i], exp_f[i]);
            end
        end
        clear_inputs();
        tick();
        checks++;
        if (pc !== 32'h6FFC || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_im_end pc=%h fault=%b want pc=6ffc fault=0", pc, fetch_fault);
        end
        tick();
        checks++;
        if (pc !== 32'h7000 || fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_cross_end pc=%h fault=%b want pc=7000 fault=1", pc, fetch_fault);
        end
        jump = 1; jump_addr = 32'h2FFC;
        tick();
        checks++;
        if (fetch_fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_below_base pc=%h fault=%b want fault=1", pc, fetch_fault);
        end
        jump_addr = 32'h3000;
        tick();
        checks++;
        if (fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_at_base pc=%h fault=%b want fault=0", pc, fetch_fault);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            exc_req     = ($urandom_range(0, 15) == 0);
            eret        = ($urandom_range(0, 11) == 0);
            stall       = ($urandom_range(0, 4) == 0);
            jump        = ($urandom_range(0, 5) == 0);
            branch      = ($urandom_range(0, 4) == 0);
            jump_addr   = $urandom_range(32'h2F00, 32'h7100);
            branch_addr = $urandom_range(32'h2F00, 32'h7100);
            epc         = $urandom_range(32'h2F00, 32'h7100);
            tick();
            checks++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || redirect !== m_redir ||
                fetch_valid !== m_valid || fetch_fault !== model_fault(m_valid, m_pc)) begin
                errors++;
                $display("FAIL random[%0d] pc=%h p4=%h redir=%b valid=%b fault=%b want pc=%h redir=%b valid=%b fault=%b",
                         n, pc, pc_plus4, redirect, fetch_valid, fetch_fault,
                         m_pc, m_redir, m_valid, model_fault(m_valid, m_pc));
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        jump = 1; jump_addr = 32'h3ABC;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 32'h3ABC || redirect !== 1'b1) begin
            errors++;
            $display("FAIL async_setup pc=%h redir=%b want pc=3abc redir=1", pc, redirect);
        end
        #2 reset_n = 0;
        #1;
        m_pc = 32'h3000; m_valid = 0; m_redir = 0;
        checks++;
        if (pc !== 32'h3000 || fetch_valid !== 1'b0 || redirect !== 1'b0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pc=%h valid=%b redir=%b fault=%b want pc=3000 valid=0 redir=0 fault=0",
                     pc, fetch_valid, redirect, fetch_fault);
        end
        tick();
        reset_n = 1;
        tick();
        tick();
        checks++;
        if (pc !== 32'h3004 || fetch_valid !== 1'b1 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL async_recover pc=%h valid=%b redir=%b want pc=3004 valid=1 redir=0",
                     pc, fetch_valid, redirect);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        @(posedge clk); #1;
        w_reset_n = 1;
        @(posedge clk); #1;
        checks++;
        if (w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b1 || w_fault !== 1'b0 || w_redirect !== 1'b0) begin
            errors++;
            $display("FAIL wrap_warmup pc=%h valid=%b fault=%b redir=%b want pc=fffffffc valid=1 fault=0 redir=0",
                     w_pc, w_valid, w_fault, w_redirect);
        end
        exp_pc = 32'hFFFF_FFFC + 32'd4;
        @(posedge clk); #1;
        checks++;
        if (w_pc !== exp_pc || w_pc !== 32'h0 || w_fault !== 1'b1 || w_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL wrap_seq pc=%h fault=%b p4=%h want pc=00000000 fault=1 p4=4", w_pc, w_fault, w_pc_plus4);
        end
    endtask

    initial begin
        w_zero    = '0;
        w_reset_n = 0;
        reset_n   = 0;
        clear_inputs();
        test_reset();
        test_priority();
        test_exception();
        test_fault();
        test_random();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
